// File: rtl/alu_pkg.sv
// alu_pkg: shared state encoding and constants for the nibble-serial ALU path
package alu_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int NIB_W = 4;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/fourbitadd.sv
// fourbitadd: 4-bit ripple adder slice with carry in/out
module fourbitadd (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit add/sub sequenced one nibble per clock through a single 4-bit slice
module nibble_serial_add_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);
    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    generate
        if (WIDTH % NIB_W != 0 || WIDTH < NIB_W) begin : g_bad_width
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_t           state, nxt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh, nxt_sum, b_in;
    logic [CW-1:0]    nib_cnt;
    logic             carry, a_msb, b_msb, s_cout, last, accept;
    logic [3:0]       s_sum;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign accept    = in_valid & in_ready;
    assign last      = nib_cnt == CW'(NIBBLES - 1);
    assign b_in      = (in_sub == OP_SUB) ? ~in_b : in_b;
    assign nxt_sum   = WIDTH'({s_sum, sum_sh} >> NIB_W);

    fourbitadd u_slice (
        .a   (a_sh[3:0]),
        .b   (b_sh[3:0]),
        .cin (carry),
        .sum (s_sum),
        .cout(s_cout)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // next state: accept -> NIBBLES slice passes -> hold result until consumed
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? RUN : IDLE;
            RUN:     nxt = last ? DONE : RUN;
            DONE:    nxt = out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    // operand load, per-nibble shift with registered carry, result capture on the last pass
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            carry    <= 1'b0;
            nib_cnt  <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (accept) begin
            a_sh    <= in_a;
            b_sh    <= b_in;
            carry   <= (in_sub == OP_SUB) ? ~in_cin : in_cin;
            nib_cnt <= '0;
            a_msb   <= in_a[WIDTH-1];
            b_msb   <= b_in[WIDTH-1];
        end else if (state == RUN) begin
            sum_sh  <= nxt_sum;
            a_sh    <= a_sh >> NIB_W;
            b_sh    <= b_sh >> NIB_W;
            carry   <= s_cout;
            nib_cnt <= nib_cnt + 1'b1;
            if (last) begin
                out_sum  <= nxt_sum;
                out_cout <= s_cout;
                out_ovf  <= (a_msb == b_msb) && (nxt_sum[WIDTH-1] != a_msb);
            end
        end
    end
endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one fourbitadd slice, one nibble per clock, LSB nibble first.
- Operands are accepted on a valid/ready input handshake.
- Nibble carry is registered between passes.
- The full result is presented on a valid/ready output handshake.
- Intended for area-constrained ALU paths where a WIDTH-bit ripple adder is too costly.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
NIBBLES, WIDTH/4, derived local constant; number of adder passes per operation

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept operands; high only in IDLE
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in (add) / borrow-in (sub)
in_sub  input  1  0 = A+B+cin, 1 = A-B-borrow
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  result
out_cout  output  1  final carry out; for sub, 1 = no borrow
out_ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (async assert, any state): state=IDLE; out_valid=0, out_sum=0, out_cout=0, out_ovf=0. in_ready=1 as soon as rst deasserts. All internal operand, sum and carry registers and the nibble counter are cleared.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, load A into shift register a_sh and B' into shift register b_sh, where B' = in_sub ? ~in_b : in_b. Set carry = in_sub ? ~in_cin : in_cin. Set nib_cnt=0. Latch the MSBs of A and B' for overflow. Go to RUN.
  - RUN: each cycle, fourbitadd gets a_sh[3:0], b_sh[3:0] and carry.
    - Its sum nibble is shifted into the sum register from the top.
    - a_sh and b_sh shift right by 4.
    - carry <= slice cout.
    - nib_cnt++.
    - When nib_cnt==NIBBLES-1, go to DONE on the same edge. That edge loads out_sum, out_cout (slice cout) and out_ovf (A_msb==B'_msb && sum_msb!=A_msb), and sets out_valid=1.
  - DONE: out_valid=1. Outputs stay stable while out_ready=0 (backpressure, unbounded). On out_ready=1, clear out_valid and go to IDLE. out_sum, out_cout and out_ovf keep their last values; they are don't-care while out_valid=0.
- in_ready = (state==IDLE) combinationally; no dependency on in_valid.
- Latency: out_valid rises exactly NIBBLES cycles after the accept edge (4 for WIDTH=16). Minimum throughput is one op per NIBBLES+2 cycles.
- Operand inputs are sampled only at the accept edge. Later changes, or in_valid held high, have no effect until IDLE.
- in_valid while not in IDLE: ignored, not queued.
- WIDTH=4: RUN lasts one cycle; nib_cnt width is max(1,$clog2(NIBBLES)).
- Arithmetic is modulo 2^WIDTH. The carry chain is unbroken across nibbles, so results are bit-identical to a WIDTH-bit ripple adder.
- Reset mid-RUN or mid-DONE: the operation is discarded and no out_valid is produced.

Decomposition:
- Shared package alu_pkg:
  - state encoding typedef (IDLE=2'd0, RUN=2'd1, DONE=2'd2)
  - NIB_W=4 constant
  - op-select constants OP_ADD=1'b0, OP_SUB=1'b1
- One sub-module instance: the existing fourbitadd as the nibble datapath (u_slice).
- Overflow logic, operand shift registers and FSM stay in this module.

Test Plan:
1. WIDTH=16, add 0x1234+0x0FFF, cin=0 -> out_sum=0x2233, cout=0, ovf=0. out_valid rises 4 cycles after accept.
2. Add 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Add 0x7FFF+0x0001 -> sum=0x8000, cout=0, ovf=1.
3. Sub 0x0005-0x0007, borrow=0 -> sum=0xFFFE, cout=0, ovf=0. Sub 0x8000-0x0001 -> sum=0x7FFF, cout=1, ovf=1.
4. Hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands driven -> outputs stable, in_ready=0. After out_ready pulse, in_ready=1 the next cycle and the new operands are accepted.
5. Assert rst for 1 cycle during RUN, at nib_cnt=2 -> outputs 0 immediately, no out_valid, in_ready=1 after release. The next op 0x0001+0x0001 returns 0x0002.
6. Back-to-back random add/sub, 1000 ops, out_ready always 1 -> every result matches a WIDTH-bit reference model. Accept-to-accept spacing is exactly NIBBLES+2 cycles.
